// File: rtl/hd_ctx_pkg.sv
// hd_ctx_pkg
//   Shared types and helpers for the HD context mover.
//   REG_W       : register / HD word width
//   REG_IDX_W   : register index width (32 general registers)
//   ctx_state_t : mover FSM states
//   slot_addr() : un-truncated HD word address of (process slot, word index)

package hd_ctx_pkg;

   localparam int REG_W     = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAVE    = 3'd1,
      ST_LOAD_RD = 3'd2,
      ST_LOAD_WR = 3'd3,
      ST_CSUM    = 3'd4,
      ST_DONE    = 3'd5
   } ctx_state_t;

   // The caller truncates to the HD address width; wrap is intended.
   function automatic int unsigned slot_addr(input int unsigned proc,
                                             input int unsigned slot_words,
                                             input int unsigned word);
      return proc * slot_words + word;
   endfunction

endpackage

// File: rtl/hd_context_mover.sv
// hd_context_mover
//   Copies a process's general registers between the register bank HD port
//   and HD memory during a context switch. Save reads the bank (reg_idx ->
//   reg_rdata) and writes HD, one word per cycle. Load reads HD (hd_addr ->
//   hd_rdata, sampled at the next clock edge) and drives the bank write path
//   one cycle later, pipelined so one word moves per cycle.
//
//   Build option HD_CTX_CHECKSUM_EN: keeps a running XOR of moved words. Save
//   stores it in slot word SLOT_WORDS-1; load reads that word back and flags
//   csum_err (held from done until the next accepted start).
//
//   Ports
//     clock, reset          system clock; synchronous active-high reset
//     start, dir, proc_id   request (dir 0 = save, 1 = load), sampled in IDLE
//     reg_idx/reg_rdata     bank HD read path
//     reg_wdata/reg_wren    bank HD write path (bank samples on negedge)
//     hd_addr/hd_wdata/hd_wren/hd_rdata   HD memory port
//     busy, done            status; done is a one-cycle pulse
//     csum_err              checksum mismatch on load (checksum build only)
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for start
//   ST_SAVE    | bank word idx is on reg_rdata; write it to HD
//   ST_LOAD_RD | HD word idx is on hd_rdata; write it to bank, issue idx+1
//   ST_LOAD_WR | last HD word on hd_rdata; final bank write
//   ST_CSUM    | checksum word write (save) or compare (load)
//   ST_DONE    | outputs quiesce; done pulses on the way out

module hd_context_mover
   import hd_ctx_pkg::*;
#(
   parameter int FIRST_REG  = 1,
   parameter int LAST_REG   = 30,
   parameter int SLOT_WORDS = 32,
   parameter int PROC_W     = 4,
   parameter int HD_ADDR_W  = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 dir,
   input  logic [PROC_W-1:0]    proc_id,
   output logic [REG_IDX_W-1:0] reg_idx,
   input  logic [REG_W-1:0]     reg_rdata,
   output logic [REG_W-1:0]     reg_wdata,
   output logic                 reg_wren,
   output logic [HD_ADDR_W-1:0] hd_addr,
   output logic [REG_W-1:0]     hd_wdata,
   output logic                 hd_wren,
   input  logic [REG_W-1:0]     hd_rdata,
   output logic                 busy,
   output logic                 done
`ifdef HD_CTX_CHECKSUM_EN
   ,
   output logic                 csum_err
`endif
);

   if (FIRST_REG > LAST_REG) begin : g_bad_range
      $error("hd_context_mover: FIRST_REG must not exceed LAST_REG");
   end

   localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
   localparam logic [REG_IDX_W-1:0] SPAN      = REG_IDX_W'(LAST_REG - FIRST_REG);
   localparam logic [REG_IDX_W-1:0] ONE       = REG_IDX_W'(1);

   ctx_state_t             state;
   logic [PROC_W-1:0]      proc_q;
   logic [REG_IDX_W-1:0]   idx;
   logic [REG_IDX_W-1:0]   remain;   // words left to move (save) / addresses left to issue (load)
`ifdef HD_CTX_CHECKSUM_EN
   logic                   dir_q;
   logic [REG_W-1:0]       csum;
`endif

   function automatic logic [HD_ADDR_W-1:0] hd_word(input logic [PROC_W-1:0] p,
                                                    input logic [31:0] w);
      return HD_ADDR_W'(slot_addr(32'(p), 32'(SLOT_WORDS), w));
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         proc_q    <= '0;
         idx       <= '0;
         remain    <= '0;
         reg_idx   <= '0;
         reg_wdata <= '0;
         reg_wren  <= 1'b0;
         hd_addr   <= '0;
         hd_wdata  <= '0;
         hd_wren   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef HD_CTX_CHECKSUM_EN
         dir_q     <= 1'b0;
         csum      <= '0;
         csum_err  <= 1'b0;
`endif
      end else begin
         done     <= 1'b0;
         reg_wren <= 1'b0;
         hd_wren  <= 1'b0;
         case (state)
            ST_IDLE: begin
               // done is still high on the first IDLE cycle; a start there is
               // treated as overlapping the finished transfer and dropped.
               if (start && !done) begin
                  proc_q <= proc_id;
                  idx    <= FIRST_IDX;
                  remain <= SPAN;
                  busy   <= 1'b1;
`ifdef HD_CTX_CHECKSUM_EN
                  dir_q    <= dir;
                  csum     <= '0;
                  csum_err <= 1'b0;
`endif
                  if (dir) begin
                     hd_addr <= hd_word(proc_id, 32'(FIRST_IDX));
                     state   <= (SPAN == '0) ? ST_LOAD_WR : ST_LOAD_RD;
                  end else begin
                     reg_idx <= FIRST_IDX;
                     state   <= ST_SAVE;
                  end
               end
            end
            ST_SAVE: begin
               hd_addr  <= hd_word(proc_q, 32'(idx));
               hd_wdata <= reg_rdata;
               hd_wren  <= 1'b1;
`ifdef HD_CTX_CHECKSUM_EN
               csum     <= csum ^ reg_rdata;
`endif
               if (remain == '0) begin
                  reg_idx <= '0;
`ifdef HD_CTX_CHECKSUM_EN
                  state   <= ST_CSUM;
`else
                  state   <= ST_DONE;
`endif
               end else begin
                  idx     <= idx + ONE;
                  reg_idx <= idx + ONE;
                  remain  <= remain - ONE;
               end
            end
            ST_LOAD_RD: begin
               reg_idx   <= idx;
               reg_wdata <= hd_rdata;
               reg_wren  <= (idx != '0);
`ifdef HD_CTX_CHECKSUM_EN
               csum      <= csum ^ hd_rdata;
`endif
               idx       <= idx + ONE;
               hd_addr   <= hd_word(proc_q, 32'(idx + ONE));
               remain    <= remain - ONE;
               if (remain == ONE) begin
                  state <= ST_LOAD_WR;
               end
            end
            ST_LOAD_WR: begin
               reg_idx   <= idx;
               reg_wdata <= hd_rdata;
               reg_wren  <= (idx != '0);
`ifdef HD_CTX_CHECKSUM_EN
               csum      <= csum ^ hd_rdata;
               hd_addr   <= hd_word(proc_q, 32'(SLOT_WORDS - 1));
               state     <= ST_CSUM;
`else
               state     <= ST_DONE;
`endif
            end
`ifdef HD_CTX_CHECKSUM_EN
            ST_CSUM: begin
               if (!dir_q) begin
                  hd_addr  <= hd_word(proc_q, 32'(SLOT_WORDS - 1));
                  hd_wdata <= csum;
                  hd_wren  <= 1'b1;
               end else begin
                  csum_err <= (hd_rdata != csum);
               end
               state <= ST_DONE;
            end
`endif
            ST_DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               reg_idx   <= '0;
               reg_wdata <= '0;
               hd_addr   <= '0;
               hd_wdata  <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
